mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the 4 KB word-addressed data memory (10-bit word address, 32-bit data, single write enable, combinational read, write on rising clk).
- Accepts CPU load/store requests with byte/halfword/word size and sign control, and drives the memory port.
- Implements sub-word stores by read-modify-write.
- Sits between the datapath's ALU result/rt register and the data memory; flags misaligned and out-of-range accesses.

Parameters:
- ADDR_LIMIT, 32'h0000_1000, first byte address outside data memory; addr >= ADDR_LIMIT is an error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe, sampled only in IDLE
- wr  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends
- addr  in  32  byte address
- wdata  in  32  store data, sub-word data in the low bits
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- addr_err  out  1  qualifies done: access aborted, memory untouched
- rdata  out  32  load result, held until the next accepted load
- dm_addr  out  10  word address to memory (byte addr[11:2])
- dm_din  out  32  write data to memory
- dm_we  out  1  memory write enable
- dm_dout  in  32  combinational read data from memory

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - busy, done, addr_err, dm_we = 0.
  - rdata, dm_din = 0; dm_addr = 0.
- States: IDLE, RD, MERGE, WR, DONE, ERR.
- IDLE:
  - On a rising edge with req=1, latch wr, size, sign_ext, addr, wdata.
  - Error check at acceptance:
    - size=11, or
    - size=01 with addr[0]=1, or
    - size=10 with addr[1:0]!=0, or
    - addr >= ADDR_LIMIT.
  - Error -> ERR.
  - Otherwise: load -> RD; word store -> WR; byte/half store -> MERGE.
- RD (load): drive dm_addr. At the closing edge, extract the lane from dm_dout, extend it, and register it into rdata. -> DONE.
- Lane selection:
  - Byte: addr[1:0]=0 selects bits [7:0] … 3 selects [31:24].
  - Half: addr[1]=0 selects [15:0]; 1 selects [31:16].
- MERGE (sub-word store): drive dm_addr. At the closing edge, register dm_din = dm_dout with the selected lane replaced by wdata[7:0] or wdata[15:0]. -> WR.
- WR:
  - dm_we=1 for exactly this one cycle, decoded from the state register.
  - dm_din is registered (word store: wdata latched at acceptance).
  - -> DONE.
- DONE: done=1, addr_err=0 for one cycle. -> IDLE.
- ERR: done=1, addr_err=1 for one cycle; no memory write; rdata unchanged. -> IDLE.
- Latency, counted from the accept edge to done high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- req while busy is ignored, not queued. A request may be accepted on the edge that leaves DONE/ERR only when the FSM is back in IDLE, so back-to-back spacing is ≥1 idle cycle.
- dm_addr holds its last value outside RD/MERGE/WR. dm_we is 0 in every state except WR.
- Reset asserted during WR: dm_we drops asynchronously, so no write occurs at the following edge.
- Reset asserted during MERGE: memory is unmodified.
- Input changes after acceptance have no effect, because all inputs are latched.

Decomposition:
- Shared package/header for:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings.
- One natural sub-module, lane_merge: combinational lane extract (with sign/zero extension) and lane insert for byte/half. Shared by the RD and MERGE paths.
- FSM and registers stay in mem_access_ctrl.

Test Plan:
- Word store then load: req wr=1 size=10 addr=0x10 wdata=0xDEADBEEF. Require dm_we high exactly one cycle with dm_addr=4 and done 2 cycles after accept. Then load word 0x10 -> rdata=0xDEADBEEF, addr_err=0.
- Byte store RMW: with word 4 = 0xDEADBEEF, store byte addr=0x13 wdata=0x12 -> word 4 = 0x12ADBEEF, done 3 cycles after accept.
- Signed/unsigned loads from word 4 = 0x12AD80EF:
  - lb addr=0x11 sign -> 0xFFFFFF80;
  - lbu 0x11 -> 0x00000080;
  - lh 0x12 sign -> 0x000012AD;
  - lh 0x10 sign -> 0xFFFF80EF.
- Errors, each giving done=addr_err=1 one cycle after accept, no dm_we pulse, rdata unchanged:
  - halfword at 0x21;
  - word at 0x22;
  - word at 0x1000;
  - size=11.
- Busy/req: hold req=1 continuously for 3 loads. Each is accepted only in IDLE; busy never drops mid-transaction; exactly 3 done pulses.
- Reset mid-op: assert rst during WR of a halfword store to 0x20 (old word 0x0). Require dm_we=0 immediately, word 8 still 0x0, all outputs at reset values; the next request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared size codes and FSM state encoding for the data-memory access controller.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_MERGE = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Combinational lane extract (sign/zero extended) and byte/half lane insert,
// shared by the load and read-modify-write store paths.
module mem_access_ctrl_lane
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b   = word[{byte_off, 3'b000} +: 8];
    lane_h   = byte_off[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    if (size == SZ_BYTE) begin
      load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
      merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SZ_HALF) begin
      load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
      if (byte_off[1]) merged[31:16] = wdata;
      else             merged[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the 4 KB word-addressed data memory; sub-word
// stores are done by read-modify-write, bad accesses abort with addr_err.
//
// state | meaning
// IDLE  | waiting for req; inputs latched and checked on acceptance
// RD    | load: read word, extract lane into rdata
// MERGE | sub-word store: read word, insert lane into dm_din
// WR    | dm_we asserted for this single cycle
// DONE  | done pulse
// ERR   | done + addr_err pulse, memory untouched
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic [31:0] rdata,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout
);

  state_t      state;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        acc_err;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    acc_err = (size == SZ_RSVD) ||
              (size == SZ_HALF && addr[0]) ||
              (size == SZ_WORD && addr[1:0] != 2'b00) ||
              (addr >= ADDR_LIMIT);
  end

  mem_access_ctrl_lane u_lane (
    .size     (size_q),
    .sign_ext (sign_q),
    .byte_off (off_q),
    .word     (dm_dout),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // Decoded from state so an async reset during WR kills the write at once.
  assign dm_we = (state == ST_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
      rdata    <= '0;
      dm_din   <= '0;
      dm_addr  <= '0;
      size_q   <= SZ_BYTE;
      sign_q   <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            busy    <= 1'b1;
            size_q  <= size;
            sign_q  <= sign_ext;
            off_q   <= addr[1:0];
            wdata_q <= wdata[15:0];
            if (acc_err) begin
              state    <= ST_ERR;
              done     <= 1'b1;
              addr_err <= 1'b1;
            end else begin
              dm_addr <= addr[11:2];
              if (!wr) begin
                state <= ST_RD;
              end else if (size == SZ_WORD) begin
                dm_din <= wdata;
                state  <= ST_WR;
              end else begin
                state <= ST_MERGE;
              end
            end
          end
        end
        ST_RD: begin
          rdata <= load_val;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_MERGE: begin
          dm_din <= merged;
          state  <= ST_WR;
        end
        ST_WR: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: directed vector table, busy/req and reset corner cases,
// then random traffic against a byte-lane reference memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, addr_err, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .addr_err(addr_err),
    .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-lane arithmetic on a plain word array.
  function automatic void model(input logic w, input logic [1:0] sz, input logic s,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic e, output int lat);
    int          width, off;
    logic [31:0] mask, word, v;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) ||
        (a >= 32'h1000);
    if (e) begin
      lat = 1;
      return;
    end
    width = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    off   = a % 4 * 8;
    mask  = (width == 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 1);
    word  = ref_mem[a / 4];
    if (!w) begin
      v = (word >> off) & mask;
      if (s && width < 32 && v[width-1]) v = v | ~mask;
      ref_rdata = v;
      lat = 2;
    end else begin
      ref_mem[a / 4] = (word & ~(mask << off)) | ((d & mask) << off);
      lat = (width == 32) ? 2 : 3;
    end
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic e, output int lat, output int we_cnt,
                        output logic [9:0] we_addr, output logic busy_ok);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; sign_ext = s; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; wr = $urandom; size = $urandom; sign_ext = $urandom;
    addr = $urandom; wdata = $urandom;
    e = 1'b0; lat = 0; we_cnt = 0; we_addr = '0; busy_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dm_we) begin
        we_cnt++;
        we_addr = dm_addr;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        e   = addr_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        s;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    int          lat;
    logic [31:0] rd;
    logic [31:0] memw;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic        e, busy_ok, me;
    int          lat, we_cnt, mlat, dn, rises, idle_cnt, extra, mism;
    logic [9:0]  we_addr;
    logic        prev_busy;
    logic        rw, rs;
    logic [1:0]  rsz;
    logic [31:0] ra, rd;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = (i == 8) ? 32'h0 : $urandom;
      ref_mem[i] = mem[i];
    end
    ref_rdata = '0;

    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 1'b0, 2, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 2, 32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13,   32'hABCDEF12, 1'b0, 3, 32'hDEADBEEF, 32'h12ADBEEF});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h10,   32'h555580EF, 1'b0, 3, 32'hDEADBEEF, 32'h12AD80EF});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        1'b0, 2, 32'hFFFFFF80, 32'h12AD80EF});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        1'b0, 2, 32'h00000080, 32'h12AD80EF});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        1'b0, 2, 32'h000012AD, 32'h12AD80EF});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        1'b0, 2, 32'h00000012, 32'h12AD80EF});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        1'b0, 2, 32'hFFFF80EF, 32'h12AD80EF});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h21,   32'h0,        1'b1, 1, 32'hFFFF80EF, 32'h0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h22,   32'h11111111, 1'b1, 1, 32'hFFFF80EF, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        1'b1, 1, 32'hFFFF80EF, 32'h0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h10,   32'h22222222, 1'b1, 1, 32'hFFFF80EF, 32'h0});

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addr_err", addr_err, 0);
    chk("reset_dm_we", dm_we, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_dm_din", dm_din, 0);
    chk("reset_dm_addr", dm_addr, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      model(vecs[i].w, vecs[i].sz, vecs[i].s, vecs[i].a, vecs[i].d, me, mlat);
      do_req(vecs[i].w, vecs[i].sz, vecs[i].s, vecs[i].a, vecs[i].d,
             e, lat, we_cnt, we_addr, busy_ok);
      chk($sformatf("vec%0d_err", i), e, vecs[i].e);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_we_pulses", i), we_cnt, (vecs[i].w && !vecs[i].e) ? 1 : 0);
      chk($sformatf("vec%0d_busy", i), busy_ok, 1);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rd);
      if (vecs[i].w && !vecs[i].e) begin
        chk($sformatf("vec%0d_we_addr", i), we_addr, vecs[i].a[11:2]);
        chk($sformatf("vec%0d_mem", i), mem[vecs[i].a[11:2]], vecs[i].memw);
      end
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), busy, 0);
    end

    // req held high across three word loads
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h10;
    dn = 0; rises = 0; idle_cnt = 0; prev_busy = busy;
    for (int c = 0; c < 40 && dn < 3; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) rises++;
      if (!busy) idle_cnt++;
      prev_busy = busy;
      if (done) begin
        dn++;
        if (dn == 3) req = 1'b0;
      end
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) extra++;
    end
    ref_rdata = ref_mem[4];
    chk("hold_req_done_pulses", dn, 3);
    chk("hold_req_accepts", rises, 3);
    chk("hold_req_idle_gaps", idle_cnt, 2);
    chk("hold_req_extra_done", extra, 0);
    chk("hold_req_rdata", rdata, ref_rdata);

    // reset while the halfword store to word 8 sits in WR
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd1; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_we_before", dm_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_dm_we", dm_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_dm_din", dm_din, 0);
    chk("rst_mid_dm_addr", dm_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = '0;
    chk("rst_mid_mem8", mem[8], 32'h0);
    model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, me, mlat);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e, lat, we_cnt, we_addr, busy_ok);
    chk("post_rst_err", e, 0);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_rdata", rdata, 32'h0);

    // random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      rw  = $urandom;
      rsz = 2'($urandom_range(0, 3));
      rs  = $urandom;
      rd  = $urandom;
      if ($urandom_range(0, 9) == 0) ra = $urandom_range(32'h1000, 32'h1FFF);
      else                           ra = $urandom_range(0, 32'hFFF);
      model(rw, rsz, rs, ra, rd, me, mlat);
      do_req(rw, rsz, rs, ra, rd, e, lat, we_cnt, we_addr, busy_ok);
      chk($sformatf("rnd%0d_err", i), e, me);
      chk($sformatf("rnd%0d_latency", i), lat, mlat);
      chk($sformatf("rnd%0d_we_pulses", i), we_cnt, (rw && !me) ? 1 : 0);
      chk($sformatf("rnd%0d_rdata", i), rdata, ref_rdata);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_mem_mismatch_words", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
